// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request/response handshake and memory pin bundle for mem_access_ctrl
interface mem_access_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_write;
  logic [7:0] rsp_rdata;
  logic [2:0] mem_adr;
  logic       mem_op;
  logic       mem_select;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_write, rsp_rdata,
    output mem_adr, mem_op, mem_select, mem_wdata, busy
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata,
    input  mem_adr, mem_op, mem_select, mem_wdata, busy
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - setup/strobe/hold sequencer in front of the 8x8 word memory
module mem_access_ctrl #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] adr_q;
  logic       op_q;
  logic [7:0] wdata_q;
  logic       rsp_write_q;
  logic [7:0] rsp_rdata_q;

  logic req_ready;
  logic select;
  logic rsp_valid;
  logic accept;
  logic strobe_end;

  // State register and phase counter; reset drops select at once because it is decoded from state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and phase count; counter restarts at 0 on every state change
  always_comb begin
    state_d   = state_q;
    cnt_d     = 4'd0;
    req_ready = 1'b0;
    select    = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = !rst;
        if (bus.req_valid && !rst) state_d = SETUP;
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) state_d = STROBE;
        else                     cnt_d   = cnt_q + 4'd1;
      end
      STROBE: begin
        select = 1'b1;
        if (cnt_q == STROBE_LAST) state_d = HOLD;
        else                      cnt_d   = cnt_q + 4'd1;
      end
      HOLD: begin
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign accept     = req_ready && bus.req_valid;
  assign strobe_end = (state_q == STROBE) && (cnt_q == STROBE_LAST);

  // Request latch onto the memory pins, op release after hold, read-data capture at strobe end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr_q       <= 3'd0;
      op_q        <= 1'b0;
      wdata_q     <= 8'h00;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      if (accept) begin
        adr_q   <= bus.req_addr;
        op_q    <= bus.req_write;
        wdata_q <= bus.req_wdata;
      end
      if (strobe_end) begin
        rsp_write_q <= op_q;
        rsp_rdata_q <= op_q ? 8'h00 : bus.mem_rdata;
      end
      if (state_q == HOLD) op_q <= 1'b0;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_write  = rsp_write_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.mem_adr    = adr_q;
  assign bus.mem_op     = op_q;
  assign bus.mem_select = select;
  assign bus.mem_wdata  = wdata_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed bench for mem_access_ctrl with two timing configurations
module tb_mem_access_ctrl;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_write;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_ready;
  int         dut_sel;
  int         checks;
  int         errors;

  logic [7:0] mem1 [8];
  logic [7:0] mem2 [8];

  mem_access_ctrl_if b1 ();
  mem_access_ctrl_if b2 ();

  mem_access_ctrl u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  mem_access_ctrl #(.SETUP_CYCLES(3), .STROBE_CYCLES(1)) u_dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

  assign b1.req_valid = req_valid && (dut_sel == 0);
  assign b1.req_write = req_write;
  assign b1.req_addr  = req_addr;
  assign b1.req_wdata = req_wdata;
  assign b1.rsp_ready = rsp_ready;
  assign b1.mem_rdata = mem1[b1.mem_adr];

  assign b2.req_valid = req_valid && (dut_sel == 1);
  assign b2.req_write = req_write;
  assign b2.req_addr  = req_addr;
  assign b2.req_wdata = req_wdata;
  assign b2.rsp_ready = rsp_ready;
  assign b2.mem_rdata = mem2[b2.mem_adr];

  // Word memory models: write on every clock edge while select and op are high
  always @(posedge clk) begin
    if (b1.mem_select && b1.mem_op) mem1[b1.mem_adr] <= b1.mem_wdata;
    if (b2.mem_select && b2.mem_op) mem2[b2.mem_adr] <= b2.mem_wdata;
  end

  logic       c_sel, c_op, c_valid, c_busy, c_ready, c_rwrite;
  logic [2:0] c_adr;
  logic [7:0] c_wdata, c_rdata;
  assign c_sel    = (dut_sel == 1) ? b2.mem_select : b1.mem_select;
  assign c_op     = (dut_sel == 1) ? b2.mem_op     : b1.mem_op;
  assign c_valid  = (dut_sel == 1) ? b2.rsp_valid  : b1.rsp_valid;
  assign c_busy   = (dut_sel == 1) ? b2.busy       : b1.busy;
  assign c_ready  = (dut_sel == 1) ? b2.req_ready  : b1.req_ready;
  assign c_rwrite = (dut_sel == 1) ? b2.rsp_write  : b1.rsp_write;
  assign c_adr    = (dut_sel == 1) ? b2.mem_adr    : b1.mem_adr;
  assign c_wdata  = (dut_sel == 1) ? b2.mem_wdata  : b1.mem_wdata;
  assign c_rdata  = (dut_sel == 1) ? b2.rsp_rdata  : b1.rsp_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request with rsp_ready high; k counts falling edges after the accept edge
  task automatic run_op(input logic w, input logic [2:0] a, input logic [7:0] d,
                        input int s, input int st, input logic [7:0] exp_rdata);
    int last;
    last = s + st + 2;
    @(negedge clk);
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    chk("ready_before_req", 32'(c_ready), 32'd1);
    @(posedge clk);
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      chk("select", 32'(c_sel), 32'((k >= s + 1) && (k <= s + st)));
      chk("rsp_valid", 32'(c_valid), 32'(k == last));
      chk("busy", 32'(c_busy), 32'(k <= last));
      chk("req_ready", 32'(c_ready), 32'(k > last));
      if (k <= last - 1) begin
        chk("mem_adr", 32'(c_adr), 32'(a));
        chk("mem_op", 32'(c_op), 32'(w));
        if (w) chk("mem_wdata", 32'(c_wdata), 32'(d));
      end
      if (k == last) begin
        chk("mem_op_resp", 32'(c_op), 32'd0);
        chk("rsp_write", 32'(c_rwrite), 32'(w));
        chk("rsp_rdata", 32'(c_rdata), 32'(exp_rdata));
      end
    end
  endtask

  initial begin
    logic got;
    int   seen;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 3'd0;
    req_wdata = 8'h00;
    rsp_ready = 1'b1;
    dut_sel   = 0;
    for (int i = 0; i < 8; i++) begin
      mem1[i] = 8'h00;
      mem2[i] = 8'h00;
    end

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_adr", 32'(b1.mem_adr), 32'd0);
    chk("rst_mem_op", 32'(b1.mem_op), 32'd0);
    chk("rst_select", 32'(b1.mem_select), 32'd0);
    chk("rst_wdata", 32'(b1.mem_wdata), 32'd0);
    chk("rst_rsp_valid", 32'(b1.rsp_valid), 32'd0);
    chk("rst_rsp_write", 32'(b1.rsp_write), 32'd0);
    chk("rst_rsp_rdata", 32'(b1.rsp_rdata), 32'd0);
    chk("rst_busy", 32'(b1.busy), 32'd0);
    chk("rst_req_ready", 32'(b1.req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("req_ready_after_rst", 32'(b1.req_ready), 32'd1);

    // Write then read back address 3
    run_op(1'b1, 3'd3, 8'hA5, 1, 2, 8'h00);
    run_op(1'b0, 3'd3, 8'h00, 1, 2, 8'hA5);

    // Walking-one pattern over every address
    for (int n = 0; n < 8; n++) run_op(1'b1, 3'(n), 8'(1 << n), 1, 2, 8'h00);
    for (int n = 0; n < 8; n++) run_op(1'b0, 3'(n), 8'h00, 1, 2, 8'(1 << n));

    // Response back-pressure with a competing request waiting
    @(negedge clk);
    rsp_ready = 1'b0;
    req_write = 1'b0;
    req_addr  = 3'd5;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    req_write = 1'b1;
    req_addr  = 3'd0;
    req_wdata = 8'h77;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(b1.rsp_valid), 32'd1);
      chk("bp_rsp_rdata", 32'(b1.rsp_rdata), 32'h20);
      chk("bp_rsp_write", 32'(b1.rsp_write), 32'd0);
      chk("bp_req_ready", 32'(b1.req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_drop", 32'(b1.rsp_valid), 32'd0);
    chk("bp_idle_ready", 32'(b1.req_ready), 32'd1);
    chk("bp_idle_busy", 32'(b1.busy), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_accept_busy", 32'(b1.busy), 32'd1);
    chk("bp_accept_adr", 32'(b1.mem_adr), 32'd0);
    chk("bp_accept_op", 32'(b1.mem_op), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (b1.rsp_valid) got = 1'b1;
    end
    chk("bp_second_rsp_seen", 32'(got), 32'd1);
    chk("bp_second_rsp_write", 32'(b1.rsp_write), 32'd1);
    run_op(1'b0, 3'd0, 8'h00, 1, 2, 8'h77);

    // Reset during the strobe of a write
    @(negedge clk);
    req_write = 1'b1;
    req_addr  = 3'd2;
    req_wdata = 8'h55;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_select_before", 32'(b1.mem_select), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_select", 32'(b1.mem_select), 32'd0);
    chk("abort_busy", 32'(b1.busy), 32'd0);
    chk("abort_rsp_valid", 32'(b1.rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b1.rsp_valid) seen++;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    chk("abort_adr_cleared", 32'(b1.mem_adr), 32'd0);
    run_op(1'b1, 3'd2, 8'h99, 1, 2, 8'h00);
    run_op(1'b0, 3'd2, 8'h00, 1, 2, 8'h99);

    // Long setup, single-cycle strobe
    dut_sel = 1;
    run_op(1'b1, 3'd6, 8'h5A, 3, 1, 8'h00);
    run_op(1'b0, 3'd6, 8'h00, 3, 1, 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
